// File: rtl/vend_coin_ctrl.sv
// ----------------------------------------------------------------------------
// vend_coin_ctrl
//
// Coin front-end controller for the water vending machine. Two coin slots
// (A, B) are arbitrated round-robin onto a single credit accumulator. Once
// credit reaches PRICE the dispenser is requested; any remainder, or the
// whole credit on cancel/timeout, is returned as back-to-back 5 Rs pulses.
//
// Coin codes: 2'b01 = 5 Rs, 2'b10 = 10 Rs, 2'b00/2'b11 = invalid (consumed,
// flagged on err_coin, credit unchanged).
//
// Optional build macro: VEND_CNT_EN
//   defined   -> adds vend_count[15:0], saturating count of completed vends
//   undefined -> port and counter absent, behaviour otherwise identical
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   coin_a_valid   in   slot A presents a coin
//   coin_a_val     in   slot A coin code [1:0]
//   coin_a_ready   out  slot A coin consumed this cycle (combinational)
//   coin_b_valid   in   slot B presents a coin
//   coin_b_val     in   slot B coin code [1:0]
//   coin_b_ready   out  slot B coin consumed this cycle (combinational)
//   cancel         in   user refund request, level
//   disp_req       out  dispense request, held until disp_ack
//   disp_ack       in   dispenser done, single-cycle pulse
//   change_pulse   out  one cycle per 5 Rs returned
//   err_coin       out  one-cycle pulse after an invalid code is consumed
//   credit         out  current credit in Rs [CREDIT_W-1:0]
//   busy           out  controller not idle
//   vend_count     out  completed vends [15:0] (VEND_CNT_EN only)
//
// States:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | no credit, waiting for first coin
//   S_COLLECT | accumulating coins, timeout counter running
//   S_DISPENSE| disp_req held, waiting for disp_ack
//   S_CHANGE  | returning remaining credit in 5 Rs pulses
// ----------------------------------------------------------------------------
module vend_coin_ctrl #(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 6,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_a_valid,
    input  logic [1:0]          coin_a_val,
    output logic                coin_a_ready,
    input  logic                coin_b_valid,
    input  logic [1:0]          coin_b_val,
    output logic                coin_b_ready,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                change_pulse,
    output logic                err_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
`ifdef VEND_CNT_EN
    ,
    output logic [15:0]         vend_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] C_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C_FIVE  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C_TEN   = CREDIT_W'(10);
    localparam logic [TO_W-1:0]     C_TO_LAST = TO_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [TO_W-1:0]     w_to_cnt_nxt;
    logic                r_ptr_b;       // 0: slot A wins a tie, 1: slot B wins
    logic                w_ptr_b_nxt;

    logic                r_disp_req;
    logic                r_change_pulse;
    logic                r_err_coin;
    logic                r_busy;

    logic                w_accept_ok;
    logic                w_grant_a;
    logic                w_grant_b;
    logic                w_coin_taken;
    logic [1:0]          w_coin_code;
    logic [CREDIT_W-1:0] w_coin_worth;
    logic                w_coin_bad;
    logic [CREDIT_W-1:0] w_credit_sum;
    logic [CREDIT_W-1:0] w_credit_after_vend;
    logic [CREDIT_W-1:0] w_credit_after_pulse;
    logic                w_vend_done;

    // ------------------------------------------------------------------
    // Slot arbitration: coins are only taken while collecting. With both
    // slots valid the pointer decides; a lone valid slot always wins.
    // ------------------------------------------------------------------
    assign w_accept_ok  = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_grant_a    = w_accept_ok && coin_a_valid && (!coin_b_valid || !r_ptr_b);
    assign w_grant_b    = w_accept_ok && coin_b_valid && (!coin_a_valid ||  r_ptr_b);
    assign w_coin_taken = w_grant_a || w_grant_b;
    assign w_coin_code  = w_grant_a ? coin_a_val : coin_b_val;

    assign coin_a_ready = w_grant_a;
    assign coin_b_ready = w_grant_b;

    always_comb begin
        w_coin_worth = '0;
        w_coin_bad   = 1'b0;
        if (w_coin_taken) begin
            case (w_coin_code)
                2'b01:   w_coin_worth = C_FIVE;
                2'b10:   w_coin_worth = C_TEN;
                default: w_coin_bad   = 1'b1;
            endcase
        end
    end

    // Pointer moves to the slot that did not just win.
    always_comb begin
        w_ptr_b_nxt = r_ptr_b;
        if (w_grant_a) begin
            w_ptr_b_nxt = 1'b1;
        end else if (w_grant_b) begin
            w_ptr_b_nxt = 1'b0;
        end
    end

    assign w_credit_sum         = r_credit + w_coin_worth;
    assign w_credit_after_vend  = r_credit - C_PRICE;
    // Guarded so that entering CHANGE with zero credit cannot wrap.
    assign w_credit_after_pulse = (r_credit == '0) ? '0 : (r_credit - C_FIVE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_to_cnt <= '0;
            r_ptr_b  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            r_ptr_b  <= w_ptr_b_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, next credit, timeout counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_to_cnt_nxt = r_to_cnt;
        w_vend_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Cancel is meaningless with no credit, so it is not looked at.
                w_credit_nxt = w_credit_sum;
                w_to_cnt_nxt = '0;
                if (w_coin_taken) begin
                    w_state_nxt = (w_credit_sum >= C_PRICE) ? S_DISPENSE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_credit_nxt = w_credit_sum;
                w_to_cnt_nxt = w_coin_taken ? '0 : (r_to_cnt + 1'b1);
                // Cancel beats reaching the price: a coin landing in the same
                // cycle as cancel is refunded along with the rest.
                if (cancel) begin
                    w_state_nxt = S_CHANGE;
                end else if (w_credit_sum >= C_PRICE) begin
                    w_state_nxt = S_DISPENSE;
                end else if (!w_coin_taken && (r_to_cnt == C_TO_LAST)) begin
                    w_state_nxt = S_CHANGE;
                end
            end
            S_DISPENSE: begin
                if (disp_ack) begin
                    w_vend_done  = 1'b1;
                    w_credit_nxt = w_credit_after_vend;
                    w_state_nxt  = (w_credit_after_vend != '0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                w_credit_nxt = w_credit_after_pulse;
                if (w_credit_after_pulse == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_credit_nxt = '0;
                w_to_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from the state/credit being entered so
    // they line up with the cycle that state is occupied.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_req     <= 1'b0;
            r_change_pulse <= 1'b0;
            r_err_coin     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_disp_req     <= (w_state_nxt == S_DISPENSE);
            r_change_pulse <= (w_state_nxt == S_CHANGE) && (w_credit_nxt != '0);
            r_err_coin     <= w_coin_bad;
            r_busy         <= (w_state_nxt != S_IDLE);
        end
    end

    assign disp_req     = r_disp_req;
    assign change_pulse = r_change_pulse;
    assign err_coin     = r_err_coin;
    assign credit       = r_credit;
    assign busy         = r_busy;

`ifdef VEND_CNT_EN
    logic [15:0] r_vend_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vend_count <= '0;
        end else if (w_vend_done && (r_vend_count != 16'hFFFF)) begin
            r_vend_count <= r_vend_count + 16'd1;
        end
    end

    assign vend_count = r_vend_count;
`else
    logic w_unused;
    assign w_unused = w_vend_done;
`endif

endmodule

// File: tb/tb_vend_coin_ctrl.sv
module tb_vend_coin_ctrl;

    localparam int PRICE    = 15;
    localparam int CREDIT_W = 6;
    localparam int TIMEOUT  = 20;
    localparam int TO_W     = 5;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_DISP    = 2;
    localparam int M_CHANGE  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                coin_a_valid;
    logic [1:0]          coin_a_val;
    logic                coin_a_ready;
    logic                coin_b_valid;
    logic [1:0]          coin_b_val;
    logic                coin_b_ready;
    logic                cancel;
    logic                disp_req;
    logic                disp_ack;
    logic                change_pulse;
    logic                err_coin;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
`ifdef VEND_CNT_EN
    logic [15:0]         vend_count;
`endif

    always #5 clk = ~clk;

    vend_coin_ctrl #(
        .PRICE(PRICE), .CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .coin_a_valid(coin_a_valid), .coin_a_val(coin_a_val), .coin_a_ready(coin_a_ready),
        .coin_b_valid(coin_b_valid), .coin_b_val(coin_b_val), .coin_b_ready(coin_b_ready),
        .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack),
        .change_pulse(change_pulse), .err_coin(err_coin), .credit(credit), .busy(busy)
`ifdef VEND_CNT_EN
        , .vend_count(vend_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the machine "is doing", how much money it holds,
    // how long it has been left alone, and who wins the next tie.
    int m_mode, m_credit, m_idle, m_ptr_b, m_vend;
    bit m_pulse, m_err;
    bit exp_a_rdy, exp_b_rdy, obs_a_rdy, obs_b_rdy;

    task automatic model_step(input bit r, input bit av, input logic [1:0] aval,
                              input bit bv, input logic [1:0] bval,
                              input bit cn, input bit ak);
        bit ok, ga, gb, got, bad;
        int worth, code;
        ok = (m_mode == M_IDLE) || (m_mode == M_COLLECT);
        ga = ok && av && (!bv || m_ptr_b == 0);
        gb = ok && bv && (!av || m_ptr_b == 1);
        exp_a_rdy = ga;
        exp_b_rdy = gb;
        got  = ga || gb;
        code = ga ? int'(aval) : int'(bval);
        worth = !got ? 0 : (code == 1) ? 5 : (code == 2) ? 10 : 0;
        bad  = got && (worth == 0);
        if (r) begin
            m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_ptr_b = 0; m_vend = 0;
            m_pulse = 0; m_err = 0;
            return;
        end
        m_err = bad;
        if (got) m_ptr_b = ga ? 1 : 0;
        case (m_mode)
            M_IDLE: begin
                m_credit += worth;
                if (got) begin
                    m_mode = (m_credit >= PRICE) ? M_DISP : M_COLLECT;
                    m_idle = 0;
                end
            end
            M_COLLECT: begin
                m_credit += worth;
                if (cn)                                     m_mode = M_CHANGE;
                else if (m_credit >= PRICE)                 m_mode = M_DISP;
                else if (!got && m_idle == TIMEOUT - 1)     m_mode = M_CHANGE;
                m_idle = got ? 0 : m_idle + 1;
            end
            M_DISP: begin
                if (ak) begin
                    m_credit -= PRICE;
                    if (m_vend < 65535) m_vend++;
                    m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
                end
            end
            default: begin
                if (m_credit > 0) m_credit -= 5;
                if (m_credit == 0) m_mode = M_IDLE;
            end
        endcase
        m_pulse = (m_mode == M_CHANGE) && (m_credit > 0);
    endtask

    task automatic drive_cycle(input bit r, input bit av, input logic [1:0] aval,
                               input bit bv, input logic [1:0] bval,
                               input bit cn, input bit ak);
        rst = r; coin_a_valid = av; coin_a_val = aval;
        coin_b_valid = bv; coin_b_val = bval; cancel = cn; disp_ack = ak;
        #1;
        obs_a_rdy = coin_a_ready;
        obs_b_rdy = coin_b_ready;
        model_step(r, av, aval, bv, bval, cn, ak);
        @(posedge clk);
        #1;
        rst = 0; coin_a_valid = 0; coin_a_val = 0;
        coin_b_valid = 0; coin_b_val = 0; cancel = 0; disp_ack = 0;
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 2'b00, 0, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        drive_cycle(1, 0, 2'b00, 0, 2'b00, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({disp_req, change_pulse, err_coin, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs got req/pulse/err/busy=%b want 0000",
                     {disp_req, change_pulse, err_coin, busy});
        end
        n_vec++;
        if (credit !== '0) begin
            n_err++; $display("FAIL reset_credit got %0d want 0", credit);
        end
`ifdef VEND_CNT_EN
        n_vec++;
        if (vend_count !== 16'd0) begin
            n_err++; $display("FAIL reset_vend_count got %0d want 0", vend_count);
        end
`endif
    endtask

    task automatic test_basic_vend();
        do_reset();
        drive_cycle(0, 1, 2'b01, 0, 2'b00, 0, 0);
        n_vec++;
        if (credit !== 6'd5 || disp_req !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL basic_first_coin credit=%0d req=%b busy=%b want 5 0 1",
                              credit, disp_req, busy);
        end
        drive_cycle(0, 1, 2'b10, 0, 2'b00, 0, 0);
        n_vec++;
        if (credit !== 6'd15 || disp_req !== 1'b1) begin
            n_err++; $display("FAIL basic_reach_price credit=%0d req=%b want 15 1", credit, disp_req);
        end
        idle_cycle();
        idle_cycle();
        n_vec++;
        if (disp_req !== 1'b1 || coin_a_ready !== 1'b0) begin
            n_err++; $display("FAIL basic_req_held req=%b want 1", disp_req);
        end
        drive_cycle(0, 0, 2'b00, 0, 2'b00, 0, 1);
        n_vec++;
        if ({disp_req, change_pulse, busy} !== 3'b000 || credit !== 6'd0) begin
            n_err++; $display("FAIL basic_after_ack req/pulse/busy=%b credit=%0d want 000 0",
                              {disp_req, change_pulse, busy}, credit);
        end
`ifdef VEND_CNT_EN
        n_vec++;
        if (vend_count !== 16'd1) begin
            n_err++; $display("FAIL basic_vend_count got %0d want 1", vend_count);
        end
`endif
    endtask

    task automatic test_arbitration();
        do_reset();
        drive_cycle(0, 1, 2'b10, 1, 2'b10, 0, 0);
        n_vec++;
        if (obs_a_rdy !== 1'b1 || obs_b_rdy !== 1'b0 || credit !== 6'd10) begin
            n_err++; $display("FAIL arb_first a_rdy=%b b_rdy=%b credit=%0d want 1 0 10",
                              obs_a_rdy, obs_b_rdy, credit);
        end
        drive_cycle(0, 1, 2'b10, 1, 2'b10, 0, 0);
        n_vec++;
        if (obs_a_rdy !== 1'b0 || obs_b_rdy !== 1'b1 || credit !== 6'd20 || disp_req !== 1'b1) begin
            n_err++; $display("FAIL arb_second a_rdy=%b b_rdy=%b credit=%0d req=%b want 0 1 20 1",
                              obs_a_rdy, obs_b_rdy, credit, disp_req);
        end
        drive_cycle(0, 0, 2'b00, 0, 2'b00, 0, 1);
        n_vec++;
        if (change_pulse !== 1'b1 || credit !== 6'd5 || disp_req !== 1'b0) begin
            n_err++; $display("FAIL arb_change pulse=%b credit=%0d req=%b want 1 5 0",
                              change_pulse, credit, disp_req);
        end
        idle_cycle();
        n_vec++;
        if (change_pulse !== 1'b0 || credit !== 6'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL arb_done pulse=%b credit=%0d busy=%b want 0 0 0",
                              change_pulse, credit, busy);
        end
    endtask

    task automatic test_cancel();
        int pulses;
        do_reset();
        drive_cycle(0, 1, 2'b01, 0, 2'b00, 0, 0);
        drive_cycle(0, 0, 2'b00, 0, 2'b00, 1, 0);
        n_vec++;
        if (change_pulse !== 1'b1 || credit !== 6'd5) begin
            n_err++; $display("FAIL cancel_pulse pulse=%b credit=%0d want 1 5", change_pulse, credit);
        end
        idle_cycle();
        n_vec++;
        if (change_pulse !== 1'b0 || busy !== 1'b0 || credit !== 6'd0) begin
            n_err++; $display("FAIL cancel_idle pulse=%b busy=%b credit=%0d want 0 0 0",
                              change_pulse, busy, credit);
        end
        // Reach COLLECT at zero credit via an invalid coin, then coin+cancel together.
        drive_cycle(0, 0, 2'b00, 1, 2'b11, 0, 0);
        drive_cycle(0, 1, 2'b10, 0, 2'b00, 1, 0);
        n_vec++;
        if (credit !== 6'd10 || change_pulse !== 1'b1) begin
            n_err++; $display("FAIL cancel_same_cycle credit=%0d pulse=%b want 10 1", credit, change_pulse);
        end
        pulses = 1;
        for (int i = 0; i < 8 && busy === 1'b1; i++) begin
            idle_cycle();
            if (change_pulse === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 2 || busy !== 1'b0) begin
            n_err++; $display("FAIL cancel_pulse_count got %0d busy=%b want 2 0", pulses, busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        drive_cycle(0, 1, 2'b01, 0, 2'b00, 0, 0);
        n = 0;
        for (int i = 0; i < TIMEOUT + 5; i++) begin
            idle_cycle();
            n++;
            if (change_pulse === 1'b1) break;
        end
        n_vec++;
        if (n != TIMEOUT || change_pulse !== 1'b1) begin
            n_err++; $display("FAIL timeout_len got %0d cycles want %0d", n, TIMEOUT);
        end
        idle_cycle();
        n_vec++;
        if (busy !== 1'b0 || credit !== 6'd0) begin
            n_err++; $display("FAIL timeout_idle busy=%b credit=%0d want 0 0", busy, credit);
        end
        do_reset();
        drive_cycle(0, 1, 2'b01, 0, 2'b00, 0, 0);
        for (int i = 0; i < TIMEOUT - 2; i++) idle_cycle();
        n_vec++;
        if (change_pulse !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL timeout_early pulse=%b busy=%b want 0 1", change_pulse, busy);
        end
        drive_cycle(0, 0, 2'b00, 1, 2'b01, 0, 0);
        n = 0;
        for (int i = 0; i < TIMEOUT + 5; i++) begin
            idle_cycle();
            n++;
            if (change_pulse === 1'b1) break;
        end
        n_vec++;
        if (n != TIMEOUT || credit !== 6'd10) begin
            n_err++; $display("FAIL timeout_restart got %0d cycles credit=%0d want %0d 10",
                              n, credit, TIMEOUT);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_invalid();
        do_reset();
        drive_cycle(0, 0, 2'b00, 1, 2'b11, 0, 0);
        n_vec++;
        if (obs_b_rdy !== 1'b1 || err_coin !== 1'b1 || credit !== 6'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL invalid_11 rdy=%b err=%b credit=%0d busy=%b want 1 1 0 1",
                              obs_b_rdy, err_coin, credit, busy);
        end
        idle_cycle();
        n_vec++;
        if (err_coin !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL invalid_err_clear err=%b busy=%b want 0 1", err_coin, busy);
        end
        drive_cycle(0, 0, 2'b00, 1, 2'b00, 0, 0);
        n_vec++;
        if (err_coin !== 1'b1 || credit !== 6'd0) begin
            n_err++; $display("FAIL invalid_00 err=%b credit=%0d want 1 0", err_coin, credit);
        end
        drive_cycle(0, 0, 2'b00, 0, 2'b00, 1, 0);
        n_vec++;
        if (change_pulse !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL invalid_cancel pulse=%b busy=%b want 0 1", change_pulse, busy);
        end
        idle_cycle();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL invalid_back_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(0, 1, 2'b10, 0, 2'b00, 0, 0);
        drive_cycle(0, 1, 2'b01, 0, 2'b00, 0, 0);
        n_vec++;
        if (disp_req !== 1'b1) begin
            n_err++; $display("FAIL rstmid_setup req=%b want 1", disp_req);
        end
        do_reset();
        n_vec++;
        if (disp_req !== 1'b0 || credit !== 6'd0 || busy !== 1'b0 || change_pulse !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs req=%b credit=%0d busy=%b pulse=%b want 0 0 0 0",
                              disp_req, credit, busy, change_pulse);
        end
`ifdef VEND_CNT_EN
        n_vec++;
        if (vend_count !== 16'd0) begin
            n_err++; $display("FAIL rstmid_vend_count got %0d want 0", vend_count);
        end
`endif
        drive_cycle(0, 1, 2'b01, 1, 2'b01, 0, 0);
        n_vec++;
        if (obs_a_rdy !== 1'b1 || obs_b_rdy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_pointer a_rdy=%b b_rdy=%b want 1 0", obs_a_rdy, obs_b_rdy);
        end
    endtask

    task automatic test_random();
        int dens;
        bit r, av, bv, cn, ak;
        logic [1:0] aval, bval;
        do_reset();
        dens = 5;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) dens = $urandom_range(0, 6);
            r    = ($urandom_range(0, 199) == 0);
            av   = ($urandom_range(0, 9) < dens);
            bv   = ($urandom_range(0, 9) < dens);
            aval = 2'($urandom_range(0, 3));
            bval = 2'($urandom_range(0, 3));
            cn   = ($urandom_range(0, 11) == 0);
            ak   = (m_mode == M_DISP) && ($urandom_range(0, 2) == 0);
            drive_cycle(r, av, aval, bv, bval, cn, ak);
            n_vec++;
            if ({obs_a_rdy, obs_b_rdy} !== {exp_a_rdy, exp_b_rdy}) begin
                n_err++; $display("FAIL rand_ready cyc=%0d got %b%b want %b%b",
                                  i, obs_a_rdy, obs_b_rdy, exp_a_rdy, exp_b_rdy);
            end
            n_vec++;
            if ({credit, disp_req, change_pulse, err_coin, busy} !==
                {CREDIT_W'(m_credit), m_mode == M_DISP, m_pulse, m_err, m_mode != M_IDLE}) begin
                n_err++; $display("FAIL rand_outputs cyc=%0d credit=%0d req=%b pulse=%b err=%b busy=%b want %0d %b %b %b %b",
                                  i, credit, disp_req, change_pulse, err_coin, busy,
                                  m_credit, m_mode == M_DISP, m_pulse, m_err, m_mode != M_IDLE);
            end
`ifdef VEND_CNT_EN
            n_vec++;
            if (vend_count !== 16'(m_vend)) begin
                n_err++; $display("FAIL rand_vend_count cyc=%0d got %0d want %0d", i, vend_count, m_vend);
            end
`endif
        end
    endtask

    initial begin
        rst = 1; coin_a_valid = 0; coin_a_val = 0; coin_b_valid = 0; coin_b_val = 0;
        cancel = 0; disp_ack = 0;
        m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_ptr_b = 0; m_vend = 0;
        m_pulse = 0; m_err = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_vend();
        test_arbitration();
        test_cancel();
        test_timeout();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
